// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD serial subtractor, diff = a - b - bin, one digit per clock, LSD first. Optional: BCD_SUB_SIGNED_MAG_EN.
// Latency: done DIGITS+1 cycles after start (2*DIGITS+1 when the signed-magnitude pass runs).
// Backpressure: none; start is taken only in IDLE, otherwise dropped (no queuing).
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  idx;
  logic           last;
  logic [W-1:0]   a_r, b_r;
  logic           brw;
  logic [3:0]     x, y, dd;
  logic [4:0]     t;
  logic           lt;

  assign last = (idx == CW'(DIGITS - 1));
  assign busy = (state == SUB) || (state == NEG);
  assign done = (state == DONE);

  // Shared digit datapath: SUB works on a_r/b_r, NEG on 0 - diff (in place).
  always_comb begin
    x = a_r[3:0];
    y = b_r[3:0];
    if (state == NEG) begin
      x = 4'd0;
      y = diff[3:0];
    end
    t  = {1'b0, x} - {1'b0, y} - {4'd0, brw};
    lt = t[4];
    dd = lt ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SUB;
      SUB: begin
        if (last) begin
`ifdef BCD_SUB_SIGNED_MAG_EN
          state_nx = lt ? NEG : DONE;
`else
          state_nx = DONE;
`endif
        end
      end
      NEG:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operands shift right; result digits enter at the top so diff ends up in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      err  <= 1'b0;
`ifdef BCD_SUB_SIGNED_MAG_EN
      neg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            brw  <= bin;
            idx  <= '0;
            err  <= 1'b0;
            bout <= 1'b0;
`ifdef BCD_SUB_SIGNED_MAG_EN
            neg  <= 1'b0;
`endif
          end
        end
        SUB: begin
          diff <= (diff >> 4) | (W'(dd) << (W - 4));
          a_r  <= a_r >> 4;
          b_r  <= b_r >> 4;
          brw  <= lt;
          if ((a_r[3:0] > 4'd9) || (b_r[3:0] > 4'd9)) err <= 1'b1;
          if (last) begin
            idx  <= '0;
            bout <= lt;
            brw  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        NEG: begin
          diff <= (diff >> 4) | (W'(dd) << (W - 4));
          brw  <= lt;
          if (last) begin
            idx <= '0;
`ifdef BCD_SUB_SIGNED_MAG_EN
            neg <= 1'b1;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_SUB_SIGNED_MAG_EN
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4), expectations follow BCD_SUB_SIGNED_MAG_EN.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, neg, err;
  logic [15:0] diff;

  int total = 0;
  int bad = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

`ifdef BCD_SUB_SIGNED_MAG_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  int          done_cyc;
  int          done_cnt;
  logic [31:0] busy_mask;

  // Start in cycle 0, then observe cycles 1..20; optional extra start pulses carry different operands.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       input int x1, input int x2);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    done_cyc = -1; done_cnt = 0; busy_mask = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_mask[k] = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == x1 || k == x2) begin
        start = 1'b1; a = 16'h9999; b = 16'h0000; bin = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (diff !== 16'h0) begin bad++; $display("FAIL reset_diff got=%h exp=0000", diff); end
    total++; if ({bout, neg, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bout, neg, err}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_op(16'h5000, 16'h1234, 1'b0, 0, 0);
    total++; if (diff !== 16'h3766) begin bad++; $display("FAIL basic_diff got=%h exp=3766", diff); end
    total++; if ({bout, neg, err} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b exp=000", {bout, neg, err}); end
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=5", done_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy_mask !== 32'h1E) begin bad++; $display("FAIL basic_busy_mask got=%h exp=0000001e", busy_mask); end
  endtask

  task automatic test_negative;
    do_op(16'h1234, 16'h5000, 1'b0, 0, 0);
    total++; if (diff !== (EN ? 16'h3766 : 16'h6234)) begin bad++; $display("FAIL neg_diff got=%h exp=%h", diff, EN ? 16'h3766 : 16'h6234); end
    total++; if (bout !== 1'b1) begin bad++; $display("FAIL neg_bout got=%b exp=1", bout); end
    total++; if (neg !== EN) begin bad++; $display("FAIL neg_sign got=%b exp=%b", neg, EN); end
    total++; if (done_cyc !== (EN ? 9 : 5)) begin bad++; $display("FAIL neg_done_cycle got=%0d exp=%0d", done_cyc, EN ? 9 : 5); end
    total++; if (busy_mask !== (EN ? 32'h1FE : 32'h1E)) begin bad++; $display("FAIL neg_busy_mask got=%h exp=%h", busy_mask, EN ? 32'h1FE : 32'h1E); end
  endtask

  task automatic test_zero_bin;
    do_op(16'h0000, 16'h0000, 1'b1, 0, 0);
    total++; if (diff !== (EN ? 16'h0001 : 16'h9999)) begin bad++; $display("FAIL zero_bin_diff got=%h exp=%h", diff, EN ? 16'h0001 : 16'h9999); end
    total++; if ({bout, neg} !== {1'b1, EN}) begin bad++; $display("FAIL zero_bin_flags got=%b exp=%b", {bout, neg}, {1'b1, EN}); end
    do_op(16'h1000, 16'h0001, 1'b1, 0, 0);
    total++; if ({diff, bout} !== {16'h0998, 1'b0}) begin bad++; $display("FAIL borrow_chain got=%h/%b exp=0998/0", diff, bout); end
  endtask

  task automatic test_equal;
    do_op(16'h4321, 16'h4321, 1'b0, 0, 0);
    total++; if (diff !== 16'h0000) begin bad++; $display("FAIL equal_diff got=%h exp=0000", diff); end
    total++; if ({bout, neg, err} !== 3'b000) begin bad++; $display("FAIL equal_flags got=%b exp=000", {bout, neg, err}); end
  endtask

  task automatic test_err;
    do_op(16'h00A3, 16'h0001, 1'b0, 0, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    total++; if ({diff, bout} !== {16'h00A2, 1'b0}) begin bad++; $display("FAIL err_diff got=%h/%b exp=00a2/0", diff, bout); end
    do_op(16'h0009, 16'h0003, 1'b0, 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    total++; if (diff !== 16'h0006) begin bad++; $display("FAIL err_next_diff got=%h exp=0006", diff); end
  endtask

  task automatic test_ignored_start;
    do_op(16'h5000, 16'h1234, 1'b0, 2, 5);
    total++; if (diff !== 16'h3766) begin bad++; $display("FAIL ignore_diff got=%h exp=3766", diff); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy_mask !== 32'h1E) begin bad++; $display("FAIL ignore_busy_mask got=%h exp=0000001e", busy_mask); end
  endtask

  task automatic test_mid_reset;
    int seen;
    @(negedge clk);
    a = 16'h5000; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, bout, neg, err} !== 5'b0) begin bad++; $display("FAIL midrst_flags got=%b exp=00000", {busy, done, bout, neg, err}); end
    total++; if (diff !== 16'h0000) begin bad++; $display("FAIL midrst_diff got=%h exp=0000", diff); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    do_op(16'h5000, 16'h1234, 1'b0, 0, 0);
    total++; if (diff !== 16'h3766) begin bad++; $display("FAIL midrst_after_diff got=%h exp=3766", diff); end
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL midrst_after_done got=%0d exp=5", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero_bin();
    test_equal();
    test_err();
    test_ignored_start();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
